// File: rtl/vldst_pkg.sv
// Shared definitions for the vector load/store unit: FSM encoding,
// operation codes and the per-vector byte count.
package vldst_pkg;

  // Controller states; every state other than IDLE reports busy.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_ADDR  = 3'd1,
    LD_LAST  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Operation select sampled with start.
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  // One vector register holds four bytes; the byte counter spans them.
  localparam int BYTES_PER_VEC = 4;
  localparam int CNT_W         = 2;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_VEC - 1);

endpackage : vldst_pkg

// File: rtl/vldst_unit.sv
// Vector load/store unit: moves one 32-bit vector register to or from
// four consecutive bytes of a synchronous byte-wide data memory.
// Loads gather bytes little-endian into a word and write it to the VRF;
// stores read the VRF once and emit four byte writes. Both take a fixed
// six cycles from the start cycle to the done pulse.
module vldst_unit
  import vldst_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [1:0]        vreg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        vrf_rreg,
  input  logic [31:0]       vrf_rdata,
  output logic [1:0]        vrf_wreg,
  output logic [31:0]       vrf_wdata,
  output logic              vrf_we
);

  // Sequential state.
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic [1:0]         r_vreg;
  logic [ADDR_W-1:0]  r_base;
  logic [31:0]        r_buf;   // store: word read from the VRF
  logic [31:0]        r_word;  // load: word assembled from memory

  // Combinational helpers.
  state_t             w_next;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_accept;
  logic               w_cnt_run;
  logic               w_capture;
  logic [CNT_W-1:0]   w_cap_idx;

  // Address wraps naturally at 2^ADDR_W because the sum is ADDR_W bits wide.
  assign w_addr    = r_base + ADDR_W'(r_cnt);
  assign w_accept  = (r_state == IDLE) && start;
  assign w_cnt_run = (r_state == LD_ADDR) || (r_state == ST_WRITE);

  // Memory read data lags the address by one cycle, so in LD_ADDR the byte
  // arriving belongs to the previous count; LD_LAST catches the final one.
  assign w_capture = ((r_state == LD_ADDR) && (r_cnt != '0)) || (r_state == LD_LAST);
  assign w_cap_idx = (r_state == LD_LAST) ? LAST_BYTE : (r_cnt - CNT_W'(1));

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Byte counter: steps through the four bytes, idle at zero otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_run) begin
      if (r_cnt == LAST_BYTE) r_cnt <= '0;
      else                    r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Request fields captured on the accepting cycle and held for the operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op   <= OP_LOAD;
      r_vreg <= '0;
      r_base <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_vreg <= vreg;
      r_base <= base_addr;
    end
  end

  // Store buffer: snapshot of the source vector register taken in ST_READ.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the data buffers are cleared on reset so no stale vector from an
    // abandoned operation can ever be observed afterwards.
    if (reset)                    r_buf <= '0;
    else if (r_state == ST_READ)  r_buf <= vrf_rdata;
  end

  // Load assembly: each returning byte lands in its little-endian lane.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_word <= '0;
    else if (w_capture) r_word[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
  end

  // Next-state and Moore outputs; all outputs idle at zero unless a state drives them.
  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    w_next    = r_state;
    busy      = (r_state != IDLE);
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    vrf_rreg  = '0;
    vrf_wreg  = '0;
    vrf_wdata = '0;
    vrf_we    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) w_next = (op == OP_LOAD) ? LD_ADDR : ST_READ;
      end
      LD_ADDR: begin
        mem_addr = w_addr;
        if (r_cnt == LAST_BYTE) w_next = LD_LAST;
      end
      LD_LAST: begin
        w_next = DONE;
      end
      ST_READ: begin
        vrf_rreg = r_vreg;
        w_next   = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = w_addr;
        mem_wdata = r_buf[{r_cnt, 3'b000} +: 8];
        if (r_cnt == LAST_BYTE) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (r_op == OP_LOAD) begin
          vrf_we    = 1'b1;
          vrf_wreg  = r_vreg;
          vrf_wdata = r_word;
        end
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule : vldst_unit

// File: doc/vldst_unit.md
VLDST_UNIT -- requirements
Module: vldst_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, byte-address width of data memory.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  1  0 = load (mem->VRF), 1 = store (VRF->mem); sampled with start.
REQ-006 SHALL have port: vreg  input  2  vector register index; sampled with start.
REQ-007 SHALL have port: base_addr  input  ADDR_W  first byte address; sampled with start.
REQ-008 SHALL have port: busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: mem_addr  output  ADDR_W  memory byte address.
REQ-011 SHALL have port: mem_wdata  output  8  memory write byte.
REQ-012 SHALL have port: mem_we  output  1  memory write enable.
REQ-013 SHALL have port: mem_rdata  input  8  read byte, valid one cycle after mem_addr is presented (synchronous memory).
REQ-014 SHALL have port: vrf_rreg  output  2  VRF read index, driving the VRF asynchronous read port.
REQ-015 SHALL have port: vrf_rdata  input  32  VRF read data, valid in the same cycle as vrf_rreg.
REQ-016 SHALL have port: vrf_wreg  output  2  VRF write index.
REQ-017 SHALL have port: vrf_wdata  output  32  VRF write data.
REQ-018 SHALL have port: vrf_we  output  1  VRF write enable; the VRF commits it on the next rising edge.

Function
REQ-019 SHALL implement the FSM states IDLE, LD_ADDR, LD_LAST, ST_READ, ST_WRITE and DONE.
REQ-020 SHALL transition from IDLE on start=1 (cycle T): to LD_ADDR if op=0, to ST_READ if op=1; op, vreg and base_addr are latched at T.
REQ-021 SHALL, in LD_ADDR (T+1..T+4, byte counter i=0..3), drive mem_addr=base+i and mem_we=0, then go to LD_LAST.
REQ-022 SHALL capture byte i of a load from mem_rdata at T+2+i into word bits [8i+7:8i]; LD_LAST (T+5) captures byte 3, then goes to DONE.
REQ-023 SHALL, in ST_READ (T+1), drive vrf_rreg=latched vreg, capture vrf_rdata into a 32-bit buffer, then go to ST_WRITE.
REQ-024 SHALL, in ST_WRITE (T+2..T+5, i=0..3), drive mem_we=1, mem_addr=base+i and mem_wdata=buffer[8i+7:8i], then go to DONE.
REQ-025 SHALL, in DONE (T+6), assert done=1; for a load also assert vrf_we=1, vrf_wreg=latched vreg and vrf_wdata=assembled word; then go to IDLE.
REQ-026 SHALL give both operations a fixed 6-cycle latency from the start cycle to done; a new start is accepted at T+7.
REQ-027 SHALL compute address arithmetic modulo 2^ADDR_W (base 0xFE yields FE, FF, 00, 01).
REQ-028 SHALL ignore start in any state other than IDLE (no queuing).
REQ-029 SHALL hold mem_we and vrf_we at 0 outside the states named above; mem_we SHALL never assert during a load, and vrf_we never during a store.
REQ-030 SHALL drive inactive data/address outputs to 0 in IDLE.

Reset
REQ-031 SHALL, on reset, immediately force state IDLE, clear the counter, latched fields and buffers, and drive busy, done, mem_we, vrf_we and all address/data outputs to 0.
REQ-032 SHALL abandon any operation interrupted by reset: no further memory writes, no VRF write and no done pulse; start is accepted on the first clock after reset deasserts.

Structure
REQ-033 SHALL place the state encoding, the OP_LOAD/OP_STORE constants and the bytes-per-vector constant (4) in shared package vldst_pkg.
REQ-034 SHALL be a single module with no sub-module; counter, FSM and byte assembly are inline.

Verification
REQ-035 SHALL test load: mem[0x10..0x13]=11,22,33,44; start op=0 vreg=2 base=0x10 at T -> at T+6 vrf_we=1, vrf_wreg=2, vrf_wdata=0x44332211, done=1.
REQ-036 SHALL test store: V1=0xDEADBEEF; start op=1 vreg=1 base=0x20 -> mem_we with EF@20, BE@21, AD@22, DE@23 at T+2..T+5, done at T+6.
REQ-037 SHALL test wrap: load with base=0xFE -> mem_addr sequence FE, FF, 00, 01, bytes assembled in that order.
REQ-038 SHALL test start held high during a busy load -> only one operation is performed and exactly one done pulse occurs.
REQ-039 SHALL test reset at T+3 of the store in REQ-036 -> only 20 and 21 are written, all outputs are 0, no done; a fresh load then completes normally.
REQ-040 SHALL test back-to-back operations: load V3 from 0x30, then store V3 to 0x40 at T+7 -> mem[0x40..0x43] equals mem[0x30..0x33].
